// File: rtl/dpc_pkg.sv
// Shared defect-pixel-correction definitions: LUT word layout and the
// bad-point writer FSM state type.
`timescale 1ns/1ps
package dpc_pkg;

  // LUT word field positions: x in the upper half, y in the lower half
  localparam int X_MSB = 31;
  localparam int X_LSB = 16;
  localparam int Y_MSB = 15;
  localparam int Y_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    COMMIT  = 2'd3
  } bpw_state_e;

  // Pack already zero-extended coordinates into one LUT word
  function automatic logic [31:0] lut_word(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] w;
    w = '0;
    w[X_MSB:X_LSB] = x;
    w[Y_MSB:Y_LSB] = y;
    return w;
  endfunction

endpackage

// File: rtl/bpw_fifo.sv
// Synchronous detection buffer for the bad-point writer. DEPTH must be a
// power of two (>= 2). flush empties the buffer and wins over push/pop.
`timescale 1ns/1ps
module bpw_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update; extra MSB separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop  && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bad_point_lut_writer.sv
// Bad-point LUT writer: buffers per-frame bad-pixel detections and writes
// them to consecutive LUT addresses, then commits the count and sticky flags.
// Optional macro BPW_ORDER_CHECK_EN: discard entries that are not strictly
// increasing in raster order and flag them in order_err.
`timescale 1ns/1ps
module bad_point_lut_writer
  import dpc_pkg::*;
#(
  parameter int WIDTH_BITS    = 10,
  parameter int HEIGHT_BITS   = 10,
  parameter int BAD_POINT_NUM = 128,
  parameter int BAD_POINT_BIT = 7,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     det_valid,
  output logic                     det_ready,
  input  logic [WIDTH_BITS-1:0]    det_x,
  input  logic [HEIGHT_BITS-1:0]   det_y,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT-1:0] waddr_lut,
  output logic [31:0]              wdata_lut,
  output logic [BAD_POINT_BIT-1:0] bad_point_num,
  output logic                     commit,
  output logic                     overflow,
  output logic                     order_err,
  output logic                     busy
);
  localparam int PW = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [BAD_POINT_BIT-1:0] CAP = BAD_POINT_BIT'(BAD_POINT_NUM - 1);

  bpw_state_e                 state;
  logic                       fs_q, fs_edge;
  logic [BAD_POINT_BIT-1:0]   count;
  logic                       ovf_f;
  logic                       push, pop, at_cap, order_ok, do_write;
  logic                       fifo_empty, fifo_full;
  logic [PW-1:0]              fifo_dout;
  logic [WIDTH_BITS-1:0]      pop_x;
  logic [HEIGHT_BITS-1:0]     pop_y;

  assign fs_edge   = frame_start & ~fs_q;
  assign det_ready = (state == COLLECT) && !fifo_full;
  assign busy      = (state != IDLE);
  assign push      = det_valid && det_ready;
  // A frame_start edge flushes the buffer, so nothing is popped that cycle
  assign pop       = ((state == COLLECT) || (state == DRAIN)) && !fifo_empty && !fs_edge;
  assign at_cap    = (count == CAP);
  assign {pop_y, pop_x} = fifo_dout;
  assign do_write  = pop && !at_cap && order_ok;

`ifdef BPW_ORDER_CHECK_EN
  logic          ord_f;
  logic [PW-1:0] last_yx;
  logic          last_vld;
  // {y,x} packing makes a numeric compare equal to raster order
  assign order_ok = !last_vld || (fifo_dout > last_yx);
`else
  assign order_ok  = 1'b1;
  assign order_err = 1'b0;
`endif

  // Entries are stored {y,x} so the raster compare needs no reshuffle
  bpw_fifo #(.W(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fs_edge),
    .push  (push),
    .din   ({det_y, det_x}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Frame FSM, LUT write port and committed results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      fs_q          <= 1'b1;
      count         <= '0;
      ovf_f         <= 1'b0;
      wen_lut       <= 1'b0;
      waddr_lut     <= '0;
      wdata_lut     <= '0;
      bad_point_num <= '0;
      commit        <= 1'b0;
      overflow      <= 1'b0;
`ifdef BPW_ORDER_CHECK_EN
      ord_f         <= 1'b0;
      last_yx       <= '0;
      last_vld      <= 1'b0;
      order_err     <= 1'b0;
`endif
    end else begin
      fs_q    <= frame_start;
      wen_lut <= 1'b0;
      commit  <= 1'b0;
      if (fs_edge) begin
        // New frame aborts whatever was in flight; committed outputs untouched
        state    <= COLLECT;
        count    <= '0;
        ovf_f    <= 1'b0;
`ifdef BPW_ORDER_CHECK_EN
        ord_f    <= 1'b0;
        last_vld <= 1'b0;
        last_yx  <= '0;
`endif
      end else begin
        if (do_write) begin
          wen_lut   <= 1'b1;
          waddr_lut <= count;
          wdata_lut <= lut_word(16'(pop_x), 16'(pop_y));
          count     <= count + BAD_POINT_BIT'(1);
`ifdef BPW_ORDER_CHECK_EN
          last_yx   <= fifo_dout;
          last_vld  <= 1'b1;
`endif
        end
        if (pop && at_cap) ovf_f <= 1'b1;
`ifdef BPW_ORDER_CHECK_EN
        if (pop && !at_cap && !order_ok) ord_f <= 1'b1;
`endif
        case (state)
          COLLECT: if (frame_end) state <= DRAIN;
          DRAIN: begin
            // Empty buffer means count and flags are final
            if (fifo_empty) begin
              state         <= COMMIT;
              bad_point_num <= count;
              overflow      <= ovf_f;
              commit        <= 1'b1;
`ifdef BPW_ORDER_CHECK_EN
              order_err     <= ord_f;
`endif
            end
          end
          COMMIT:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bad_point_lut_writer.sv
// Directed self-checking bench for bad_point_lut_writer (default parameters).
// Expectations for the order-check case follow BPW_ORDER_CHECK_EN.
`timescale 1ns/1ps
module tb_bad_point_lut_writer;
  logic        clk, rst_n;
  logic        frame_start, frame_end;
  logic        det_valid, det_ready;
  logic [9:0]  det_x, det_y;
  logic        wen_lut;
  logic [6:0]  waddr_lut;
  logic [31:0] wdata_lut;
  logic [6:0]  bad_point_num;
  logic        commit, overflow, order_err, busy;

  int nchk = 0, nerr = 0;
  int ncommit = 0, stalls = 0, bad_wen = 0;
  logic [6:0]  wa[$];
  logic [31:0] wd[$];

  bad_point_lut_writer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
    .det_valid(det_valid), .det_ready(det_ready), .det_x(det_x), .det_y(det_y),
    .wen_lut(wen_lut), .waddr_lut(waddr_lut), .wdata_lut(wdata_lut),
    .bad_point_num(bad_point_num), .commit(commit), .overflow(overflow),
    .order_err(order_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write/commit monitor sampled mid-cycle
  always @(negedge clk) begin
    if (wen_lut) begin
      wa.push_back(waddr_lut);
      wd.push_back(wdata_lut);
      if (commit || !busy) bad_wen++;
    end
    if (commit) ncommit++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b0;
    step();
    wa.delete(); wd.delete();
    frame_start = 1'b1;
    step();
  endtask

  task automatic end_frame();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  task automatic send(input int x, input int y);
    logic acc;
    acc = 1'b0;
    det_valid = 1'b1;
    det_x = 10'(x);
    det_y = 10'(y);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (det_ready) acc = 1'b1; else stalls++;
      step();
    end
    det_valid = 1'b0;
    chk("accept", 32'(acc), 1);
  endtask

  task automatic wait_commit();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      if (commit) seen = 1'b1;
    end
    chk("commit_seen", 32'(seen), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    det_valid = 1'b0; det_x = '0; det_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(det_ready), 0);
    chk("rst_wen", 32'(wen_lut), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bpn", 32'(bad_point_num), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_oerr", 32'(order_err), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic frame plus two-cycle write latency on the first detection
    start_frame();
    send(3, 1);
    @(negedge clk); chk("lat_c1_wen", 32'(wen_lut), 0);
    @(negedge clk); chk("lat_c2_wen", 32'(wen_lut), 1);
    chk("lat_c2_addr", 32'(waddr_lut), 0);
    step();
    send(7, 1);
    send(2, 5);
    end_frame();
    wait_commit();
    chk("f1_nwr", wa.size(), 3);
    chk("f1_a0", 32'(wa[0]), 0); chk("f1_d0", wd[0], 32'h0003_0001);
    chk("f1_a1", 32'(wa[1]), 1); chk("f1_d1", wd[1], 32'h0007_0001);
    chk("f1_a2", 32'(wa[2]), 2); chk("f1_d2", wd[2], 32'h0002_0005);
    chk("f1_bpn", 32'(bad_point_num), 3);
    chk("f1_ovf", 32'(overflow), 0);
    step();
    chk("f1_idle", 32'(busy), 0);

    // Overflow: 130 increasing detections, capacity 127
    start_frame();
    for (int i = 0; i < 130; i++) send(i, 1);
    end_frame();
    wait_commit();
    chk("ov_nwr", wa.size(), 127);
    chk("ov_last_a", 32'(wa[126]), 126);
    chk("ov_last_d", wd[126], 32'h007E_0001);
    chk("ov_bpn", 32'(bad_point_num), 127);
    chk("ov_flag", 32'(overflow), 1);

    // Order check: duplicate and backwards entries
    start_frame();
    send(5, 2); send(5, 2); send(4, 2);
    end_frame();
    wait_commit();
`ifdef BPW_ORDER_CHECK_EN
    chk("ord_nwr", wa.size(), 1);
    chk("ord_bpn", 32'(bad_point_num), 1);
    chk("ord_err", 32'(order_err), 1);
`else
    chk("ord_nwr", wa.size(), 3);
    chk("ord_bpn", 32'(bad_point_num), 3);
    chk("ord_err", 32'(order_err), 0);
    chk("ord_d2", wd[2], 32'h0004_0002);
`endif
    chk("ord_ovf", 32'(overflow), 0);

    // 20 back-to-back detections: no backpressure, all written in order
    start_frame();
    stalls = 0;
    for (int i = 0; i < 20; i++) send(10 + i, 3);
    end_frame();
    wait_commit();
    chk("b2b_stalls", stalls, 0);
    chk("b2b_nwr", wa.size(), 20);
    for (int i = 0; i < 20 && i < wa.size(); i++) begin
      chk("b2b_a", 32'(wa[i]), i);
      chk("b2b_d", wd[i], {16'(10 + i), 16'd3});
    end
    chk("b2b_bpn", 32'(bad_point_num), 20);

    // Frame restarted during DRAIN: no commit, old count kept, new frame at 0
    step();
    c0 = ncommit;
    start_frame();
    frame_start = 1'b0;
    send(1, 1); send(2, 2);
    end_frame();
    frame_start = 1'b1;
    step();
    wa.delete(); wd.delete();
    repeat (5) step();
    chk("abort_ncommit", ncommit, c0);
    chk("abort_bpn", 32'(bad_point_num), 20);
    chk("abort_busy", 32'(busy), 1);
    send(9, 9);
    end_frame();
    wait_commit();
    chk("restart_nwr", wa.size(), 1);
    chk("restart_a0", 32'(wa[0]), 0);
    chk("restart_d0", wd[0], 32'h0009_0009);
    chk("restart_bpn", 32'(bad_point_num), 1);

    // Reset pulse mid-COLLECT
    step();
    start_frame();
    send(1, 1); send(2, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_wen", 32'(wen_lut), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ready", 32'(det_ready), 0);
    chk("mrst_bpn", 32'(bad_point_num), 0);
    step();
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    det_valid = 1'b1; det_x = 10'd3; det_y = 10'd3;
    repeat (10) step();
    @(negedge clk);
    chk("mrst_idle_ready", 32'(det_ready), 0);
    det_valid = 1'b0;
    chk("mrst_nwr", wa.size(), 0);
    chk("mrst_idle_busy", 32'(busy), 0);
    step();
    start_frame();
    send(4, 4);
    end_frame();
    wait_commit();
    chk("mrst_new_d0", wd[0], 32'h0004_0004);
    chk("mrst_new_bpn", 32'(bad_point_num), 1);

    step();
    chk("wen_outside_frame", bad_wen, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
